// File: rtl/sdio_pkg.sv
// Shared SDIO data-path definitions: completion status codes and the
// multi-block sequencer state encoding.
package sdio_pkg;

    localparam logic [1:0] SDIO_ST_OK      = 2'd0;
    localparam logic [1:0] SDIO_ST_CRC     = 2'd1;
    localparam logic [1:0] SDIO_ST_TIMEOUT = 2'd2;
    localparam logic [1:0] SDIO_ST_ABORT   = 2'd3;

    typedef enum logic [2:0] {
        XFER_IDLE,
        XFER_START,
        XFER_WAIT_BLK,
        XFER_BUSY_WAIT,
        XFER_GAP,
        XFER_DONE
    } xfer_state_e;

endpackage

// File: rtl/sdio_timeout_cnt.sv
// Loadable down-counter with clear and enable; expired_o is high while the
// count sits at zero. Shared by the write-busy watchdog and the gap timer.
module sdio_timeout_cnt #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/sdio_data_xfer_ctrl.sv
// Multi-block SDIO transfer sequencer: walks the block handler through N
// blocks with inter-block gaps and write-busy polling, then reports status.
module sdio_data_xfer_ctrl
    import sdio_pkg::*;
#(
    parameter int BLK_SIZE_W = 12,
    parameter int BLK_CNT_W  = 9,
    parameter int GAP_CYC    = 2,
    parameter int BUSY_TO    = 16'hFFFF
) (
    input  logic                  sd_clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [BLK_SIZE_W-1:0] cmd_blk_size,
    input  logic [BLK_CNT_W-1:0]  cmd_blk_cnt,
    input  logic                  abort,
    output logic                  blk_start,
    output logic                  blk_dir,
    output logic [BLK_SIZE_W:0]   blk_len,
    output logic                  blk_abort,
    input  logic                  blk_done,
    input  logic                  blk_crc_err,
    input  logic                  blk_timeout,
    input  logic                  dat0_busy,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            status,
    output logic [BLK_CNT_W-1:0]  blocks_done
);

    localparam int GAP_W  = $clog2(GAP_CYC + 1);
    localparam int BUSY_W = $clog2(BUSY_TO + 1);
    // Both timers expire at zero, so they are loaded one short of their span.
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_CYC - 1);
    localparam logic [BUSY_W-1:0] BUSY_LOAD = BUSY_W'(BUSY_TO - 1);

    xfer_state_e          state_q;
    logic                 blk_dir_q;
    logic                 blk_abort_q;
    logic [BLK_SIZE_W:0]  blk_len_q;
    logic [BLK_CNT_W-1:0] rem_q;
    logic [BLK_CNT_W-1:0] blocks_done_q;
    logic [1:0]           status_q;

    logic blk_ok;
    logic gap_load;
    logic busy_load;
    logic cnt_clr;
    logic gap_expired;
    logic busy_expired;

    always_comb begin
        blk_ok    = (state_q == XFER_WAIT_BLK) && blk_done && !blk_crc_err && !blk_timeout;
        busy_load = blk_ok && blk_dir_q;
        gap_load  = (blk_ok && !blk_dir_q && (rem_q != BLK_CNT_W'(1)))
                 || ((state_q == XFER_BUSY_WAIT) && !dat0_busy && (rem_q != '0));
        cnt_clr   = (state_q == XFER_IDLE);
    end

    sdio_timeout_cnt #(.W(GAP_W)) u_gap_cnt (
        .clk_i      (sd_clk),
        .rst_ni     (rst_n),
        .clr_i      (cnt_clr),
        .load_i     (gap_load),
        .load_val_i (GAP_LOAD),
        .en_i       (state_q == XFER_GAP),
        .expired_o  (gap_expired)
    );

    sdio_timeout_cnt #(.W(BUSY_W)) u_busy_wdog (
        .clk_i      (sd_clk),
        .rst_ni     (rst_n),
        .clr_i      (cnt_clr),
        .load_i     (busy_load),
        .load_val_i (BUSY_LOAD),
        .en_i       ((state_q == XFER_BUSY_WAIT) && dat0_busy),
        .expired_o  (busy_expired)
    );

    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= XFER_IDLE;
            blk_dir_q     <= 1'b0;
            blk_len_q     <= '0;
            blk_abort_q   <= 1'b0;
            rem_q         <= '0;
            blocks_done_q <= '0;
            status_q      <= SDIO_ST_OK;
        end else begin
            blk_abort_q <= 1'b0;
            unique case (state_q)
                XFER_IDLE: begin
                    if (cmd_valid) begin
                        blk_dir_q     <= cmd_write;
                        blk_len_q     <= {cmd_blk_size, 1'b0};
                        rem_q         <= cmd_blk_cnt;
                        blocks_done_q <= '0;
                        status_q      <= SDIO_ST_OK;
                        state_q       <= (cmd_blk_cnt == '0) ? XFER_DONE : XFER_START;
                    end
                end
                XFER_START: state_q <= XFER_WAIT_BLK;
                XFER_WAIT_BLK: begin
                    if (blk_done) begin
                        if (blk_crc_err) begin
                            state_q  <= XFER_DONE;
                            status_q <= SDIO_ST_CRC;
                        end else if (blk_timeout) begin
                            state_q  <= XFER_DONE;
                            status_q <= SDIO_ST_TIMEOUT;
                        end else begin
                            blocks_done_q <= blocks_done_q + BLK_CNT_W'(1);
                            rem_q         <= rem_q - BLK_CNT_W'(1);
                            if (blk_dir_q)
                                state_q <= XFER_BUSY_WAIT;
                            else if (rem_q == BLK_CNT_W'(1))
                                state_q <= XFER_DONE;
                            else
                                state_q <= XFER_GAP;
                        end
                    end
                end
                XFER_BUSY_WAIT: begin
                    // rem_q was already decremented, so zero marks the last block.
                    if (!dat0_busy) begin
                        state_q <= (rem_q == '0) ? XFER_DONE : XFER_GAP;
                    end else if (busy_expired) begin
                        state_q  <= XFER_DONE;
                        status_q <= SDIO_ST_TIMEOUT;
                    end
                end
                XFER_GAP:  if (gap_expired) state_q <= XFER_START;
                XFER_DONE: state_q <= XFER_IDLE;
                default:   state_q <= XFER_IDLE;
            endcase
            // Abort overrides any block outcome; a clean block still counts.
            if (abort && (state_q != XFER_IDLE) && (state_q != XFER_DONE)) begin
                state_q     <= XFER_DONE;
                status_q    <= SDIO_ST_ABORT;
                blk_abort_q <= (state_q == XFER_WAIT_BLK) || (state_q == XFER_BUSY_WAIT);
            end
        end
    end

    assign cmd_ready   = (state_q == XFER_IDLE);
    assign busy        = (state_q != XFER_IDLE);
    assign blk_start   = (state_q == XFER_START);
    assign done        = (state_q == XFER_DONE);
    assign blk_dir     = blk_dir_q;
    assign blk_len     = blk_len_q;
    assign blk_abort   = blk_abort_q;
    assign status      = status_q;
    assign blocks_done = blocks_done_q;

endmodule
